qspi_flash_responder: RTL

Synthesizable QSPI NOR-flash responder: the device end of the QSPI link driven by the SlurmBoy flash controller. It oversamples the host's SCLK, CSb and IO lines on CLK, decodes the read opcodes, and serves bytes from an on-chip memory read port. It is used as the flash stand-in for FPGA bring-up and as the reference device in controller benches.

---
 rtl/qspi_flash_pkg.sv | 26 ++
 rtl/qspi_in_sync.sv | 48 ++++
 rtl/qspi_flash_responder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/qspi_flash_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | qspi_flash_pkg                                                           |
// | Opcodes and responder state encoding shared by the QSPI flash responder, |
// | the flash controller and their benches.                                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package qspi_flash_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_QREAD = 8'h6B;
  localparam logic [7:0] OP_RDID  = 8'h9F;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DUMMY  = 3'd3,
    ST_DATA_S = 3'd4,
    ST_DATA_Q = 3'd5,
    ST_ID     = 3'd6,
    ST_IGNORE = 3'd7
  } qspi_state_e;

endpackage
`default_nettype wire

// File: rtl/qspi_in_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | qspi_in_sync                                                             |
// | 2-FF synchronizers for the QSPI pads with edge pulses for SCLK and CSb.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module qspi_in_sync (
  input  logic       CLK,
  input  logic       RSTb,
  input  logic       i_sclk,
  input  logic       i_csb,
  input  logic [3:0] i_io,
  output logic       o_sclk_rise,
  output logic       o_sclk_fall,
  output logic       o_csb_rise,
  output logic       o_csb_fall,
  output logic [3:0] o_io
);

  // [0],[1] synchronize, [2] holds the previous synchronized value
  logic [2:0] r_sclk;
  logic [2:0] r_csb;
  logic [3:0] r_io_meta;
  logic [3:0] r_io_sync;

  // CSb history resets low, so a select held low across reset yields no fall
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      r_sclk    <= 3'b000;
      r_csb     <= 3'b000;
      r_io_meta <= 4'h0;
      r_io_sync <= 4'h0;
    end else begin
      r_sclk    <= {r_sclk[1:0], i_sclk};
      r_csb     <= {r_csb[1:0], i_csb};
      r_io_meta <= i_io;
      r_io_sync <= r_io_meta;
    end
  end

  assign o_sclk_rise = r_sclk[1] & ~r_sclk[2];
  assign o_sclk_fall = ~r_sclk[1] & r_sclk[2];
  assign o_csb_rise  = r_csb[1] & ~r_csb[2];
  assign o_csb_fall  = ~r_csb[1] & r_csb[2];
  assign o_io        = r_io_sync;

endmodule
`default_nettype wire

// File: rtl/qspi_flash_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | qspi_flash_responder                                                     |
// | QSPI NOR-flash device model: decodes 03/6B/9F and serves memory bytes.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module qspi_flash_responder
  import qspi_flash_pkg::*;
#(
  parameter int          ADDR_W       = 24,
  parameter logic [23:0] JEDEC_ID     = 24'hEF4018,
  parameter int          DUMMY_CYCLES = 8
) (
  input  logic              CLK,
  input  logic              RSTb,
  input  logic              qspi_sclk,
  input  logic              qspi_csb,
  input  logic [3:0]        qspi_io_in,
  output logic [3:0]        qspi_io_out,
  output logic [3:0]        qspi_io_oe,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              cmd_error
);

  localparam logic [5:0] c_dummy_last = 6'(DUMMY_CYCLES - 1);

  logic        w_sclk_rise, w_sclk_fall, w_csb_rise, w_csb_fall;
  logic [3:0]  w_io;
  logic        w_unused_io;
  logic [23:0] w_rx_next;
  logic [4:0]  w_id_sel;
  logic        w_bad_op;
  logic [3:0]  w_oe_nxt;
  qspi_state_e r_state, w_state_nxt;

  logic [5:0]        r_cnt;
  logic [23:0]       r_rx;
  logic              r_quad;
  logic [ADDR_W-1:0] r_addr;
  logic              r_mem_rd, r_rd_d;
  logic [7:0]        r_nbuf, r_tx;
  logic [4:0]        r_id_pos;
  logic [3:0]        r_io_out, r_oe;
  logic              r_cmd_err;

  qspi_in_sync u_sync (
    .CLK         (CLK),
    .RSTb        (RSTb),
    .i_sclk      (qspi_sclk),
    .i_csb       (qspi_csb),
    .i_io        (qspi_io_in),
    .o_sclk_rise (w_sclk_rise),
    .o_sclk_fall (w_sclk_fall),
    .o_csb_rise  (w_csb_rise),
    .o_csb_fall  (w_csb_fall),
    .o_io        (w_io)
  );

  // Only IO0 carries host bits for the supported single-input opcodes
  assign w_unused_io = ^w_io[3:1];
  assign w_rx_next   = {r_rx[22:0], w_io[0]};
  assign w_id_sel    = 5'd23 - r_id_pos;

  always_ff @(posedge CLK) begin
    if (!RSTb) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bad_op    = 1'b0;
    w_oe_nxt    = 4'h0;
    if (w_csb_rise) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_csb_fall) w_state_nxt = ST_CMD;
        ST_CMD: begin
          if (w_sclk_rise && r_cnt == 6'd7) begin
            if (w_rx_next[7:0] == OP_READ || w_rx_next[7:0] == OP_QREAD) begin
              w_state_nxt = ST_ADDR;
            end else if (w_rx_next[7:0] == OP_RDID) begin
              w_state_nxt = ST_ID;
            end else begin
              w_state_nxt = ST_IGNORE;
              w_bad_op    = 1'b1;
            end
          end
        end
        ST_ADDR:  if (w_sclk_rise && r_cnt == 6'd23) w_state_nxt = r_quad ? ST_DUMMY : ST_DATA_S;
        ST_DUMMY: if (w_sclk_rise && r_cnt == c_dummy_last) w_state_nxt = ST_DATA_Q;
        default:  ;
      endcase
    end
    case (w_state_nxt)
      ST_DATA_S, ST_ID: w_oe_nxt = 4'b0010;
      ST_DATA_Q:        w_oe_nxt = 4'hF;
      default:          w_oe_nxt = 4'h0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      r_cnt     <= 6'd0;
      r_rx      <= 24'h0;
      r_quad    <= 1'b0;
      r_addr    <= '0;
      r_mem_rd  <= 1'b0;
      r_rd_d    <= 1'b0;
      r_nbuf    <= 8'h0;
      r_tx      <= 8'h0;
      r_id_pos  <= 5'd0;
      r_io_out  <= 4'h0;
      r_oe      <= 4'h0;
      r_cmd_err <= 1'b0;
    end else begin
      r_mem_rd  <= 1'b0;
      r_rd_d    <= r_mem_rd;
      r_cmd_err <= w_bad_op;
      r_oe      <= w_oe_nxt;
      if (r_rd_d) r_nbuf <= mem_rdata;
      if (w_csb_rise) begin
        r_cnt    <= 6'd0;
        r_id_pos <= 5'd0;
        r_io_out <= 4'h0;
      end else begin
        case (r_state)
          ST_IDLE: if (w_csb_fall) begin
            r_cnt    <= 6'd0;
            r_id_pos <= 5'd0;
          end
          ST_CMD: if (w_sclk_rise) begin
            r_rx   <= w_rx_next;
            r_quad <= (w_rx_next[7:0] == OP_QREAD);
            r_cnt  <= (r_cnt == 6'd7) ? 6'd0 : r_cnt + 6'd1;
          end
          ST_ADDR: if (w_sclk_rise) begin
            r_rx <= w_rx_next;
            if (r_cnt == 6'd23) begin
              r_cnt    <= 6'd0;
              r_addr   <= w_rx_next[ADDR_W-1:0];
              r_mem_rd <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 6'd1;
            end
          end
          ST_DUMMY: if (w_sclk_rise) r_cnt <= (r_cnt == c_dummy_last) ? 6'd0 : r_cnt + 6'd1;
          // First bit/nibble of a byte comes from the prefetch buffer and triggers the next fetch
          ST_DATA_S: if (w_sclk_fall) begin
            r_cnt <= (r_cnt == 6'd7) ? 6'd0 : r_cnt + 6'd1;
            if (r_cnt == 6'd0) begin
              r_io_out <= {2'b00, r_nbuf[7], 1'b0};
              r_tx     <= {r_nbuf[6:0], 1'b0};
              r_addr   <= r_addr + 1'b1;
              r_mem_rd <= 1'b1;
            end else begin
              r_io_out <= {2'b00, r_tx[7], 1'b0};
              r_tx     <= {r_tx[6:0], 1'b0};
            end
          end
          ST_DATA_Q: if (w_sclk_fall) begin
            r_cnt <= (r_cnt == 6'd1) ? 6'd0 : r_cnt + 6'd1;
            if (r_cnt == 6'd0) begin
              r_io_out <= r_nbuf[7:4];
              r_tx     <= r_nbuf;
              r_addr   <= r_addr + 1'b1;
              r_mem_rd <= 1'b1;
            end else begin
              r_io_out <= r_tx[3:0];
            end
          end
          ST_ID: if (w_sclk_fall) begin
            r_io_out <= {2'b00, JEDEC_ID[w_id_sel], 1'b0};
            r_id_pos <= (r_id_pos == 5'd23) ? 5'd0 : r_id_pos + 5'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign qspi_io_out = r_io_out;
  assign qspi_io_oe  = r_oe;
  assign mem_rd      = r_mem_rd;
  assign mem_addr    = r_addr;
  assign busy        = (r_state != ST_IDLE);
  assign cmd_error   = r_cmd_err;

endmodule
`default_nettype wire
